serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial ripple adder built around a single full-adder cell and a carry flip-flop. It adds two WIDTH-bit operands LSB first, one bit per clock, and accumulates the result in a shift register. It is the sequential consumer of the one-bit full-adder sum/carry stage: that stage is reused every cycle instead of being replicated WIDTH times. It is driven by a start/done handshake.

## Interface
- WIDTH, 8, operand and result width in bits; legal values are WIDTH >= 2.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  one-cycle pulse; sum and cout are valid while it is high.
- sum  output  WIDTH  result register; held from done until the next accepted start.
- cout  output  1  final carry-out; held like sum.
- ovf  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **Reset:** rst=1 at a clock edge sets state to IDLE and clears busy, done, sum, cout, ovf, the bit counter and the internal operand registers.
- **Reset mid-operation:** same as above; the operation in progress is aborted and no done pulse follows.
- **IDLE:** start=1 causes the following on the same edge:
  - a and b load into shift registers.
  - The carry flop loads cin.
  - The counter clears to 0.
  - sum clears to 0.
  - State goes to SHIFT.
- **SHIFT, each edge:**
  - The bit sum is a[0]^b[0]^carry.
  - The new carry is majority(a[0], b[0], carry).
  - sum shifts right, with the bit sum inserted at the MSB.
  - The a and b registers shift right, with 0 inserted at the MSB.
  - The counter increments.
- **SHIFT, edge with counter==WIDTH-1:** the last bit is processed, cout takes the new carry, and state goes to DONE.
- **DONE:** lasts one cycle with done=1, then state returns to IDLE.
  - start=1 in DONE is accepted exactly as in IDLE, which allows back-to-back operations.
- start during SHIFT is ignored; it is neither queued nor does it restart the operation.
- a, b and cin may change freely after the accepted start edge.
- **Width rules:**
  - The counter is $clog2(WIDTH) bits wide.
  - The result is the unsigned (a+b+cin) mod 2^WIDTH.
  - cout is bit WIDTH of that sum.

## Timing
- **Start edge E0:** start is accepted and busy is high from the cycle after E0.
- **Edges E1..E_WIDTH:** process bits 0..WIDTH-1.
- **Cycle after E_WIDTH:** busy=0 and done=1, with sum and cout final.
- **Latency:** WIDTH cycles from the start edge to done; throughput is one operation per WIDTH+1 cycles.
- **Outputs:** all outputs are registered, with no combinational path from inputs to outputs.
- **During SHIFT:** sum holds a partial value and is not meaningful until done.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - The ovf port exists.
  - On the final SHIFT edge, ovf takes carry-into-MSB XOR carry-out-of-MSB.
  - ovf is held like cout and cleared on reset and on an accepted start.
- SERIAL_ADDER_OVF_EN undefined: the ovf port and its logic are absent; all other behaviour is identical.

## Structure
- **Package serial_adder_pkg:**
  - State enum typedef (IDLE, SHIFT, DONE).
  - Default WIDTH constant.
- **Sub-module fa_cell:** combinational one-bit full adder with inputs a, b, c and outputs sum, carry; instantiated once in the datapath.
- The FSM, counter and shift registers live in serial_adder itself.

## Test plan
- **Basic add:** WIDTH=8, a=0x5A, b=0x3C, cin=0, pulse start -> done exactly 8 cycles after the start edge, sum=0x96, cout=0.
- **Wrap-around:** a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Also a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- **Start while busy:** start held high for 3 cycles mid-SHIFT -> result unchanged, single done pulse.
- **Back-to-back:** second start asserted in the DONE cycle with a=0x10, b=0x20 -> second done 8 cycles later with sum=0x30.
- **Reset mid-operation:** rst=1 at bit 4 -> next cycle busy=0, done=0, sum=0, cout=0, and no done pulse follows. A subsequent start works normally.
- **Overflow (SERIAL_ADDER_OVF_EN defined):**
  - a=0x7F, b=0x01 -> ovf=1, sum=0x80.
  - a=0xFF, b=0x01 -> ovf=0, cout=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types, constants and bit-level helpers for the
// bit-serial adder. The optional signed-overflow output is controlled by the
// SERIAL_ADDER_OVF_EN macro in serial_adder.sv.
package serial_adder_pkg;

  // Default operand/result width in bits (legal values are >= 2).
  localparam int DEFAULT_WIDTH = 8;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Three-input exclusive OR (full-adder sum bit).
  function automatic logic xor3(input logic x, input logic y, input logic z);
    return x ^ y ^ z;
  endfunction

  // Three-input majority (full-adder carry bit).
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// fa_cell: purely combinational one-bit full adder. The serial adder
// instantiates a single copy and reuses it every cycle.
module fa_cell
  import serial_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = xor3(a, b, c);
  assign carry = maj3(a, b, c);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder. Two WIDTH-bit operands are added LSB
// first, one bit per clock, through one shared full-adder cell and a carry
// flop; the result is accumulated in a right-shifting register.
// Handshake: start (accepted in IDLE or DONE) -> busy during SHIFT -> one-cycle
// done pulse with sum/cout final.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed-overflow
// output ovf (carry into MSB XOR carry out of MSB), held like cout.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Counter sized to index every bit position of the operands.
  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_ZERO = CW'(0);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  state_e           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             busy_r;
  logic             done_r;
  logic             ovf_r;

  logic             fa_sum_s;
  logic             fa_carry_s;
  logic             accept_s;
  logic             last_bit_s;

  // The single full-adder stage, fed from the operand LSBs and the carry flop.
  fa_cell u_fa (
    .a     (a_r[0]),
    .b     (b_r[0]),
    .c     (carry_r),
    .sum   (fa_sum_s),
    .carry (fa_carry_s)
  );

  // Decode: a start request is honoured only in IDLE or DONE; flag the final bit.
  always_comb begin
    accept_s   = 1'b0;
    last_bit_s = 1'b0;
    if ((state_r == IDLE) || (state_r == DONE)) begin
      accept_s = start;
    end else begin
      accept_s = 1'b0;
    end
    if ((state_r == SHIFT) && (cnt_r == LAST_CNT)) begin
      last_bit_s = 1'b1;
    end else begin
      last_bit_s = 1'b0;
    end
  end

  // Control FSM, operand/result shift registers, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= CNT_ZERO;
      sum_r   <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          // done is a single-cycle pulse; it always drops after DONE.
          done_r <= 1'b0;
          if (accept_s) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            cnt_r   <= CNT_ZERO;
            sum_r   <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= SHIFT;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          // One bit per edge; start is deliberately ignored here.
          sum_r   <= {fa_sum_s, sum_r[WIDTH-1:1]};
          a_r     <= {1'b0, a_r[WIDTH-1:1]};
          b_r     <= {1'b0, b_r[WIDTH-1:1]};
          carry_r <= fa_carry_s;
          cnt_r   <= cnt_r + CNT_ONE;
          if (last_bit_s) begin
            // carry_r is the carry into the MSB, fa_carry_s the carry out.
            cout_r  <= fa_carry_s;
            ovf_r   <= carry_r ^ fa_carry_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= SHIFT;
          end
        end
        default: begin
          // Unreachable encoding: recover to a quiet IDLE.
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          cnt_r   <= CNT_ZERO;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

`ifdef SERIAL_ADDER_OVF_EN
  assign ovf = ovf_r;
`else
  // Overflow register is still built for a uniform reset structure but is
  // unobservable and will be trimmed; keep lint quiet about it being unused.
  logic unused_ovf_s;
  assign unused_ovf_s = ovf_r;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder (WIDTH=8) using a
// scoreboard queue of expected results checked whenever done is seen.
// Build with +define+SERIAL_ADDER_OVF_EN to also check ovf.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   d0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Count a comparison and report it when observed differs from expected.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition, signed overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    exp_t        e;
    logic [W:0]  s9;
    s9     = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
    e.sum  = s9[W-1:0];
    e.cout = s9[W];
    e.ovf  = (ta[W-1] == tb[W-1]) && (s9[W-1] != ta[W-1]);
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check("sum", 32'(sum), 32'(mon_e.sum));
        check("cout", 32'(cout), 32'(mon_e.cout));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", 32'(ovf), 32'(mon_e.ovf));
`endif
      end
    end
  end

  // Launch one addition (called #1 after an edge) and wait for done, checking latency.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input bit poke);
    int k;
    a     = ta;
    b     = tb;
    cin   = tc;
    start = 1'b1;
    sb_q.push_back(model(ta, tb, tc));
    @(posedge clk); #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
    k = 0;
    while (k < 20) begin
      @(posedge clk); #1;
      k++;
      if (poke && (k == 2)) start = 1'b1;
      if (poke && (k == 5)) start = 1'b0;
      if (done === 1'b1) break;
    end
    check("latency", 32'(k), 32'(W));
    check("busy_at_done", 32'(busy), 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    cin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic add and result hold after done.
    do_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("sum_hold", 32'(sum), 32'h96);
    check("done_pulse_width", 32'(done), 32'd0);

    // Wrap-around cases.
    do_op(8'hFF, 8'h01, 1'b0, 1'b0);
    @(posedge clk); #1;
    do_op(8'h00, 8'h00, 1'b1, 1'b0);
    @(posedge clk); #1;

    // Start held for three cycles mid-SHIFT must be ignored.
    d0 = done_cnt;
    do_op(8'h12, 8'h34, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("single_done", 32'(done_cnt - d0), 32'd1);
    check("no_restart_busy", 32'(busy), 32'd0);

    // Back-to-back: second start issued during the DONE cycle.
    do_op(8'h11, 8'h22, 1'b1, 1'b0);
    do_op(8'h10, 8'h20, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("b2b_sum_hold", 32'(sum), 32'h30);

    // Reset while bit 4 is about to be processed.
    a     = 8'hC3;
    b     = 8'h5F;
    cin   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("midrst_ovf", 32'(ovf), 32'd0);
`endif
    d0 = done_cnt;
    repeat (12) @(posedge clk);
    #1;
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    do_op(8'hA5, 8'h0F, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Signed overflow corners (ovf only checked when the feature is built).
    do_op(8'h7F, 8'h01, 1'b0, 1'b0);
    @(posedge clk); #1;
    do_op(8'h80, 8'h80, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Random operations.
    for (int i = 0; i < 6; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      @(posedge clk); #1;
    end

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
